comparador_serial: RTL and testbench
====================================

// Module: comparador_serial
// PURPOSE
//   Multi-cycle, mode-selectable magnitude/equality comparator for the datapath.
//   Replaces the single-function A==B block. Supports EQ/NE/unsigned/signed
//   relational tests on WIDTH-bit operands, processed CHUNK bits per cycle,
//   MSB chunk first. Uses a start/busy/done handshake toward the control unit.
// PARAMETERS
//   WIDTH  32  operand width in bits
//   CHUNK   8  bits compared per cycle; WIDTH % CHUNK must be 0 (elaboration $error otherwise)
//   NCHUNK (localparam) WIDTH/CHUNK, number of compare cycles
// PORTS
//   clk     in   1      clock, rising edge
//   reset   in   1      synchronous, active-high reset
//   start   in   1      request; sampled only in IDLE
//   mode    in   3      0 EQ, 1 NE, 2 LTU, 3 GEU, 4 LTS, 5 GES, 6-7 reserved
//   a       in   WIDTH  operand A; captured on accepted start
//   b       in   WIDTH  operand B; captured on accepted start
//   busy    out  1      high whenever state != IDLE
//   done    out  1      one-cycle pulse: result/flags valid
//   result  out  1      selected-mode outcome; held until next accepted start
//   eq      out  1      A==B flag, held
//   lt_u    out  1      A<B unsigned flag, held
//   lt_s    out  1      A<B signed (two's complement) flag, held
// BEHAVIOUR
//   - Reset: state IDLE; busy, done, result, eq, lt_u, lt_s all 0. Reset
//     mid-operation aborts immediately; the captured operation is discarded.
//   - FSM IDLE -> BUSY -> DONE -> IDLE.
//     IDLE: start=1 captures a, b, mode; idx=NCHUNK-1; diff=0; go to BUSY.
//     BUSY: compare chunk idx. If !diff and the chunks differ: diff=1,
//       ltu_r = (a_chunk < b_chunk) unsigned. Decrement idx. At idx==0 go to DONE.
//     DONE: done=1 for exactly one cycle; go to IDLE.
//   - Latency: start sampled at edge 0 -> done high after edge NCHUNK.
//     The next start is accepted in the cycle after done.
//   - Flags are registered on the BUSY->DONE edge:
//     eq = !diff; lt_u = ltu_r;
//     lt_s = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : ltu_r.
//   - result: EQ=eq, NE=!eq, LTU=lt_u, GEU=!lt_u, LTS=lt_s, GES=!lt_s.
//     Reserved modes: result=0; flags are still computed.
//   - start while busy is ignored. a, b, mode may change freely after capture.
//   - NCHUNK==1: single BUSY cycle; done after edge 1.
// CONFIGURATION
//   CMP_EARLY_EXIT_EN defined: on the first differing chunk, BUSY goes to DONE
//     on that edge. Latency is 1..NCHUNK (equal operands always take NCHUNK).
//   CMP_EARLY_EXIT_EN undefined: latency is fixed at NCHUNK. Flag values are
//     identical in both builds.
// STRUCTURE
//   Shared package cmp_pkg: mode encoding localparams (CMP_EQ..CMP_GES), FSM
//   state encoding (ST_IDLE, ST_BUSY, ST_DONE).
//   Sub-module cmp_chunk #(CHUNK): combinational slice compare giving ne and lt_u.
//   The top level holds the FSM, chunk index counter, operand registers and
//   flag registers.
// TESTING (WIDTH=32, CHUNK=8)
//   - a=b=0x12345678, mode EQ -> done after 4 cycles; result=1, eq=1, lt_u=0, lt_s=0.
//   - a=0xFFFFFFFF, b=0x00000001: mode LTS -> result=1 (lt_s=1);
//     rerun with mode LTU -> result=0 (lt_u=0).
//   - a=0x80000000, b=0, mode GEU -> result=1. Latency is 1 cycle with
//     CMP_EARLY_EXIT_EN and 4 cycles without it.
//   - a=0x00000010, b=0x00000020, mode NE; start pulsed again during BUSY ->
//     ignored; exactly one done; result=1, lt_u=1.
//   - reset asserted on the 2nd BUSY cycle -> next cycle busy=0, done=0, all
//     flags 0; a new start then completes normally.
//   - mode=6, a=b -> done; result=0, eq=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg: mode and FSM state encodings shared by the serial comparator.
`default_nettype none

package cmp_pkg;

  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LTU = 3'd2;
  localparam logic [2:0] CMP_GEU = 3'd3;
  localparam logic [2:0] CMP_LTS = 3'd4;
  localparam logic [2:0] CMP_GES = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Reserved modes (6, 7) yield 0 while the flags stay valid.
  function automatic logic mode_result(input logic [2:0] mode,
                                       input logic       eq,
                                       input logic       lt_u,
                                       input logic       lt_s);
    logic r;
    case (mode)
      CMP_EQ:  r = eq;
      CMP_NE:  r = !eq;
      CMP_LTU: r = lt_u;
      CMP_GEU: r = !lt_u;
      CMP_LTS: r = lt_s;
      CMP_GES: r = !lt_s;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_chunk.sv
// cmp_chunk: combinational compare of one CHUNK-bit operand slice.
`default_nettype none

module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             ne_o,
  output logic             lt_u_o
);

  assign ne_o   = (a_i != b_i);
  assign lt_u_o = (a_i <  b_i);

endmodule

`default_nettype wire

// File: rtl/comparador_serial.sv
// comparador_serial: multi-cycle EQ/NE/LTU/GEU/LTS/GES comparator, MSB chunk first.
// Optional build macro CMP_EARLY_EXIT_EN ends the scan at the first differing chunk.
`default_nettype none

module comparador_serial
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic             eq,
  output logic             lt_u,
  output logic             lt_s
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_cfg
      $error("comparador_serial: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       mode_q;
  logic             diff_q, diff_d;
  logic             ltu_q, ltu_d;
  logic             eq_q, lt_u_q, lt_s_q, result_q;

  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             chunk_ne, chunk_lt;
  logic             first_diff;
  logic             lts_d;

  assign chunk_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign chunk_b = b_q[int'(idx_q) * CHUNK +: CHUNK];

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i    (chunk_a),
    .b_i    (chunk_b),
    .ne_o   (chunk_ne),
    .lt_u_o (chunk_lt)
  );

  // Only the most significant differing chunk decides the unsigned order.
  assign first_diff = !diff_q && chunk_ne;
  assign diff_d     = diff_q || chunk_ne;
  assign ltu_d      = first_diff ? chunk_lt : ltu_q;
  assign lts_d      = (a_q[WIDTH-1] != b_q[WIDTH-1]) ? a_q[WIDTH-1] : ltu_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: begin
        if (idx_q == '0) state_d = ST_DONE;
`ifdef CMP_EARLY_EXIT_EN
        if (first_diff) state_d = ST_DONE;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      diff_q   <= 1'b0;
      ltu_q    <= 1'b0;
      eq_q     <= 1'b0;
      lt_u_q   <= 1'b0;
      lt_s_q   <= 1'b0;
      result_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        a_q    <= a;
        b_q    <= b;
        mode_q <= mode;
        idx_q  <= IDXW'(NCHUNK - 1);
        diff_q <= 1'b0;
        ltu_q  <= 1'b0;
      end
      if (state_q == ST_BUSY) begin
        diff_q <= diff_d;
        ltu_q  <= ltu_d;
        if (idx_q != '0) idx_q <= idx_q - 1'b1;
        if (state_d == ST_DONE) begin
          eq_q     <= !diff_d;
          lt_u_q   <= ltu_d;
          lt_s_q   <= lts_d;
          result_q <= mode_result(mode_q, !diff_d, ltu_d, lts_d);
        end
      end
    end
  end

  assign result = result_q;
  assign eq     = eq_q;
  assign lt_u   = lt_u_q;
  assign lt_s   = lt_s_q;

endmodule

`default_nettype wire

// File: tb/tb_comparador_serial.sv
// tb_comparador_serial: directed vectors for comparador_serial (WIDTH=32, CHUNK=8).
`default_nettype none

module tb_comparador_serial;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, result, eq, lt_u, lt_s;

  int nvec = 0;
  int nmis = 0;

  comparador_serial #(.WIDTH(32), .CHUNK(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .eq     (eq),
    .lt_u   (lt_u),
    .lt_s   (lt_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef CMP_EARLY_EXIT_EN
    for (int i = 3; i >= 0; i--)
      if (x[i*8 +: 8] != y[i*8 +: 8]) return 4 - i;
`endif
    return 4;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Issues one operation and returns with the done cycle being sampled.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [2:0] tm);
    int  lat = 0;
    bit  got = 0;
    wait_idle();
    a = ta; b = tb_v; mode = tm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; mode = 3'($urandom_range(0, 7));
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      got = done;
    end
    check({tag, "_lat"}, lat, exp_lat(ta, tb_v));
  endtask

  initial begin
    int ndone, first;
    logic r_res, r_ltu;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_eq", eq, 0);
    check("rst_ltu", lt_u, 0);
    check("rst_lts", lt_s, 0);

    run_op("eq", 32'h12345678, 32'h12345678, 3'd0);
    check("eq_result", result, 1);
    check("eq_eq", eq, 1);
    check("eq_ltu", lt_u, 0);
    check("eq_lts", lt_s, 0);

    run_op("lts", 32'hFFFFFFFF, 32'h00000001, 3'd4);
    check("lts_result", result, 1);
    check("lts_lts", lt_s, 1);
    run_op("ltu", 32'hFFFFFFFF, 32'h00000001, 3'd2);
    check("ltu_result", result, 0);
    check("ltu_ltu", lt_u, 0);

    run_op("geu", 32'h80000000, 32'h00000000, 3'd3);
    check("geu_result", result, 1);

    run_op("negneg", 32'hFFFFFFFE, 32'hFFFFFFFF, 3'd4);
    check("negneg_result", result, 1);
    check("negneg_ltu", lt_u, 1);

    // NE with a second start pulse while busy: must be ignored.
    wait_idle();
    a = 32'h00000010; b = 32'h00000020; mode = 3'd1; start = 1'b1;
    @(posedge clk); #1;
    check("ne_busy", busy, 1);
    ndone = 0; first = 0; r_res = 0; r_ltu = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      start = (cyc == 2);
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = cyc; r_res = result; r_ltu = lt_u;
        end
      end
    end
    start = 1'b0;
    check("ne_ndone", ndone, 1);
    check("ne_lat", first, 4);
    check("ne_result", r_res, 1);
    check("ne_ltu", r_ltu, 1);

    // Reset during the second BUSY cycle aborts the operation.
    wait_idle();
    a = 32'hA5A5A5A5; b = 32'hA5A5A5A5; mode = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_pre", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_eq", eq, 0);
    check("abort_ltu", lt_u, 0);
    check("abort_lts", lt_s, 0);
    ndone = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_nodone", ndone, 0);

    run_op("ges", 32'h7FFFFFFF, 32'h80000000, 3'd5);
    check("ges_result", result, 1);
    check("ges_ltu", lt_u, 1);
    check("ges_lts", lt_s, 0);

    run_op("rsv", 32'hCAFEF00D, 32'hCAFEF00D, 3'd6);
    check("rsv_result", result, 0);
    check("rsv_eq", eq, 1);

    @(posedge clk); #1;
    check("done_pulse", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
